// File: rtl/fir_eq_pkg.sv
// Shared constants, FSM state type and coefficient ROM for the audio-path
// FIR equaliser.
package fir_eq_pkg;

  localparam int FIR_IN_W      = 24;
  localparam int FIR_SAMPLE_W  = 16;
  localparam int FIR_NTAPS     = 4;
  localparam int FIR_COEF_W    = 16;
  localparam int FIR_ACC_W     = 2 * FIR_SAMPLE_W + $clog2(FIR_NTAPS);
  localparam int FIR_TAP_W     = $clog2(FIR_NTAPS);
  localparam int FIR_NPROFILES = 4;
  localparam int FIR_PROF_W    = $clog2(FIR_NPROFILES);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  typedef logic [FIR_PROF_W-1:0]        profile_t;
  typedef logic signed [FIR_COEF_W-1:0] coef_t;

  // Row = profile, column = tap k (k=0 multiplies the newest sample).
  localparam coef_t COEF_ROM [FIR_NPROFILES][FIR_NTAPS] = '{
    '{16'sd1,  16'sd0, 16'sd0, 16'sd0},
    '{16'sd1,  16'sd1, 16'sd1, 16'sd1},
    '{16'sd4,  16'sd1, 16'sd2, 16'sd1},
    '{16'sd1, -16'sd1, 16'sd0, 16'sd0}
  };

  // Unknown profile codes fall back to bypass.
  function automatic profile_t profile_sel(input logic [7:0] eq_val);
    profile_t p;
    if (eq_val > 8'd3) begin
      p = '0;
    end else begin
      p = eq_val[FIR_PROF_W-1:0];
    end
    return p;
  endfunction

  function automatic coef_t coef_lookup(input profile_t p,
                                        input logic [FIR_TAP_W-1:0] k);
    return COEF_ROM[p][k];
  endfunction

endpackage

// File: rtl/fir_sample_window.sv
// Sample delay line for the equaliser: window[0] holds the newest sample,
// window[NTAPS-1] the oldest.
module fir_sample_window
  import fir_eq_pkg::*;
#(
  parameter int SAMPLE_W = FIR_SAMPLE_W,
  parameter int NTAPS    = FIR_NTAPS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              shift_en,
  input  logic signed [SAMPLE_W-1:0]        sample,
  output logic [NTAPS-1:0][SAMPLE_W-1:0]    window
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
    end else if (shift_en) begin
      window <= {window[NTAPS-2:0], sample};
    end
  end

endmodule

// File: rtl/fir_eq_filter.sv
// Streaming 4-tap FIR equaliser: one accepted sample triggers a sequential
// multiply-accumulate (one tap per clock) and a single-cycle done strobe.
module fir_eq_filter
  import fir_eq_pkg::*;
#(
  parameter int IN_W     = FIR_IN_W,
  parameter int SAMPLE_W = FIR_SAMPLE_W,
  parameter int NTAPS    = FIR_NTAPS,
  parameter int COEF_W   = FIR_COEF_W,
  parameter int ACC_W    = FIR_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     signal_en,
  input  logic signed [IN_W-1:0]   signal,
  input  logic [7:0]               eqVal,
  output logic signed [ACC_W-1:0]  result_o,
  output logic                     done
);

  localparam int TAP_W  = $clog2(NTAPS);
  localparam int PROD_W = SAMPLE_W + COEF_W;

  fir_state_e                       state_p0;
  fir_state_e                       state_nxt;
  logic                             shift_en;
  logic                             acc_en;
  logic                             out_en;
  logic                             last_tap;
  profile_t                         profile_p0;
  logic [TAP_W-1:0]                 tap_p1;
  logic signed [ACC_W-1:0]          acc_p1;
  logic [NTAPS-1:0][SAMPLE_W-1:0]   window;
  logic signed [SAMPLE_W-1:0]       sample_new;
  logic signed [SAMPLE_W-1:0]       tap_sample;
  logic signed [COEF_W-1:0]         tap_coef;
  logic signed [PROD_W-1:0]         prod;
  logic                             unused_lsbs;

  function automatic logic signed [ACC_W-1:0] sext_prod(
    input logic signed [PROD_W-1:0] p
  );
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Truncation keeps the top SAMPLE_W bits; the remaining LSBs are dropped.
  assign sample_new  = signal[IN_W-1:IN_W-SAMPLE_W];
  assign unused_lsbs = ^signal[IN_W-SAMPLE_W-1:0];

  fir_sample_window #(
    .SAMPLE_W (SAMPLE_W),
    .NTAPS    (NTAPS)
  ) u_window (
    .clk      (clk),
    .rst      (reset),
    .shift_en (shift_en),
    .sample   (sample_new),
    .window   (window)
  );

  assign last_tap   = (tap_p1 == TAP_W'(NTAPS - 1));
  assign tap_sample = $signed(window[tap_p1]);
  assign tap_coef   = coef_lookup(profile_p0, tap_p1);
  assign prod       = PROD_W'(tap_sample) * PROD_W'(tap_coef);

  always_comb begin
    state_nxt = state_p0;
    shift_en  = 1'b0;
    acc_en    = 1'b0;
    out_en    = 1'b0;
    case (state_p0)
      IDLE: begin
        if (signal_en) begin
          shift_en  = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        acc_en = 1'b1;
        if (last_tap) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        out_en    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Stage p0: profile captured with the sample; later eqVal changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      profile_p0 <= '0;
    end else if (shift_en) begin
      profile_p0 <= profile_sel(eqVal);
    end
  end

  // Stage p1: sequential MAC, one tap per clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p1 <= '0;
      tap_p1 <= '0;
    end else if (shift_en) begin
      acc_p1 <= '0;
      tap_p1 <= '0;
    end else if (acc_en) begin
      acc_p1 <= acc_p1 + sext_prod(prod);
      tap_p1 <= tap_p1 + TAP_W'(1);
    end
  end

  // Stage p2: registered result; held until the next completed computation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_o <= '0;
      done     <= 1'b0;
    end else begin
      done <= out_en;
      if (out_en) begin
        result_o <= acc_p1;
      end
    end
  end

endmodule

// File: tb/tb_fir_eq_filter.sv
// Self-checking bench for fir_eq_filter: vector table plus scoreboarded
// corner-case sequences.
module tb_fir_eq_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic               signal_en;
  logic [23:0]        signal;
  logic [7:0]         eqVal;
  logic signed [33:0] result_o;
  logic               done;

  fir_eq_filter dut (
    .clk       (clk),
    .reset     (reset),
    .signal_en (signal_en),
    .signal    (signal),
    .eqVal     (eqVal),
    .result_o  (result_o),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [33:0] res;
    int                 due;
  } exp_t;

  typedef struct {
    logic [23:0]        sig;
    logic [7:0]         eq;
    logic signed [33:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs [22];

  int mw [4];
  int ctab [4][4] = '{'{1, 0, 0, 0}, '{1, 1, 1, 1}, '{4, 1, 2, 1}, '{1, -1, 0, 0}};

  function automatic void model_shift(input logic [23:0] s);
    mw[3] = mw[2];
    mw[2] = mw[1];
    mw[1] = mw[0];
    mw[0] = int'($signed(s[23:8]));
  endfunction

  function automatic logic signed [33:0] model_eval(input logic [7:0] eq);
    int     p;
    longint sum;
    p   = (eq > 8'd3) ? 0 : int'(eq);
    sum = 0;
    for (int k = 0; k < 4; k++) sum += longint'(mw[k]) * longint'(ctab[p][k]);
    return 34'(sum);
  endfunction

  task automatic check(input string name, input logic signed [33:0] act,
                       input logic signed [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic send(input logic [23:0] s, input logic [7:0] e,
                      input logic signed [33:0] exp);
    signal    = s;
    eqVal     = e;
    signal_en = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{exp, cyc + 5});
    model_shift(s);
    signal_en = 1'b0;
    eqVal     = ~e;
    signal    = ~s;
    drain(12);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual=%0d required=no_done", result_o);
      end else begin
        mon_e = sb.pop_front();
        if (result_o !== mon_e.res) begin
          errors++;
          $display("FAIL result actual=%0d required=%0d", result_o, mon_e.res);
        end
        checks++;
        if (cyc != mon_e.due) begin
          errors++;
          $display("FAIL latency actual_cycle=%0d required_cycle=%0d", cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int          next_ok;
  logic [23:0] s_rand;

  initial begin
    vecs = '{
      '{24'h000100, 8'd2,   34'sd4},  '{24'h000200, 8'd2,   34'sd9},
      '{24'h000300, 8'd2,   34'sd16}, '{24'h000400, 8'd2,   34'sd24},
      '{24'h000100, 8'd0,   34'sd1},  '{24'h000200, 8'd0,   34'sd2},
      '{24'h000300, 8'd0,   34'sd3},  '{24'h000400, 8'd0,   34'sd4},
      '{24'h000100, 8'd1,   34'sd10}, '{24'h000200, 8'd1,   34'sd10},
      '{24'h000300, 8'd1,   34'sd10}, '{24'h000400, 8'd1,   34'sd10},
      '{24'h000100, 8'd3,  -34'sd3},  '{24'h000200, 8'd3,   34'sd1},
      '{24'h000300, 8'd3,   34'sd1},  '{24'h000400, 8'd3,   34'sd1},
      '{24'h000100, 8'hFF,  34'sd1},  '{24'h000200, 8'hFF,  34'sd2},
      '{24'h000300, 8'hFF,  34'sd3},  '{24'h000400, 8'hFF,  34'sd4},
      '{24'hFFFF00, 8'd0,   34'h3_FFFF_FFFF},
      '{24'h800000, 8'd2,  -34'sd131062}
    };
    for (int k = 0; k < 4; k++) mw[k] = 0;

    reset     = 1'b1;
    signal_en = 1'b0;
    signal    = '0;
    eqVal     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, 34'sd0);
    check("reset_done", {33'd0, done}, 34'sd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("idle_done", {33'd0, done}, 34'sd0);
      check("idle_result", result_o, 34'sd0);
    end

    for (int i = 0; i < 22; i++) send(vecs[i].sig, vecs[i].eq, vecs[i].exp);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("hold_result", result_o, vecs[21].exp);
    end

    next_ok = 0;
    for (int i = 0; i < 40; i++) begin
      s_rand    = 24'($urandom);
      signal    = s_rand;
      eqVal     = 8'd1;
      signal_en = 1'b1;
      @(posedge clk);
      #1;
      if (cyc >= next_ok) begin
        model_shift(s_rand);
        sb.push_back('{model_eval(8'd1), cyc + 5});
        next_ok = cyc + 6;
      end
    end
    signal_en = 1'b0;
    drain(12);

    signal    = 24'h000500;
    eqVal     = 8'd1;
    signal_en = 1'b1;
    @(posedge clk);
    #1;
    signal_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_result", result_o, 34'sd0);
    check("abort_done", {33'd0, done}, 34'sd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) mw[k] = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", {33'd0, done}, 34'sd0);
    end
    send(24'h000700, 8'd1, 34'sd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_eq_filter.md
Name:
fir_eq_filter

Overview:
- Streaming 4-tap FIR equaliser for the audio path.
- Each accepted 24-bit input sample is truncated to 16 bits and shifted into a 4-deep sample window.
- A sequential multiply-accumulate then runs one tap per clock, using a coefficient profile selected by eqVal.
- The signed sum is presented on result_o with a one-cycle done strobe.
- Sits between the audio sample source and the output/DAC stage.

Parameters:
- IN_W, 24: input sample width.
- SAMPLE_W, 16: window sample width; sample = signal[IN_W-1:IN_W-SAMPLE_W].
- NTAPS, 4: taps and window depth.
- COEF_W, 16: signed coefficient width.
- ACC_W, 34: accumulator/result width (2*SAMPLE_W + log2(NTAPS)).

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- signal_en, in, 1: input sample valid for this cycle.
- signal, in, IN_W: signed input sample.
- eqVal, in, 8: coefficient profile select.
- result_o, out, ACC_W: signed filter output, registered.
- done, out, 1: one-cycle pulse; result_o updated this cycle.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - window[0..3] = 0, accumulator = 0, tap index = 0.
  - result_o = 0, done = 0, state = IDLE.
  - Reset asserted mid-computation aborts the computation; no done pulse follows.
- States:
  - IDLE: waiting for a sample.
  - MAC: accumulating, one tap per clock.
  - OUT: drives the result and done.
- IDLE with signal_en=1 at a clock edge:
  - Shift the window: window[3]<=window[2], window[2]<=window[1], window[1]<=window[0], window[0]<=signal[23:8].
  - Latch the profile from eqVal.
  - Clear the accumulator and tap index; go to MAC.
- IDLE with signal_en=0: hold all state.
- MAC, each cycle:
  - acc <= acc + sext(window[k]) * sext(coef[profile][k]); full signed 32-bit product, sign-extended to ACC_W.
  - k increments by 1.
  - After k=3 (4th MAC cycle), go to OUT.
- OUT, one cycle:
  - result_o <= acc; done=1; return to IDLE.
  - done is high exactly one cycle.
  - result_o holds its value until the next OUT.
- Latency: with the sample accepted at edge N, result_o/done are valid after edge N+5.
  - Minimum spacing between accepted samples is 6 cycles.
- signal_en asserted outside IDLE (MAC/OUT): the sample is ignored; the window is not modified.
- eqVal changes mid-computation have no effect until the next accepted sample.
- Coefficient profiles (signed, taps k=0..3), selected by eqVal:
  - 0: {1,0,0,0} (bypass).
  - 1: {1,1,1,1} (moving sum).
  - 2: {4,1,2,1}.
  - 3: {1,-1,0,0} (difference).
  - eqVal > 3 selects profile 0.
- Arithmetic:
  - Two's complement throughout.
  - ACC_W=34 covers the worst case of 4 full-scale products, so no overflow or saturation is possible.

Decomposition:
- Package fir_eq_pkg:
  - Width/NTAPS constants.
  - State enum (IDLE, MAC, OUT).
  - Coefficient ROM as a constant array [4][NTAPS] plus a profile-select function with the >3 clamp.
- One sub-module, fir_sample_window: shift-register window with enable and async reset, exposing window[0..NTAPS-1].
- Top level holds the FSM, tap counter, MAC and output registers.

Test Plan:
- Reset, then idle 10 cycles with signal_en=0 -> result_o=0, done never asserted, window all zero.
- Profile 2 (eqVal=2); feed 24'h000100, 000200, 000300, 000400, each after the previous done.
  - Window ends {4,3,2,1} (newest first).
  - Final done after the 4th sample gives result_o=24 (4*4+1*3+2*2+1*1).
  - Earlier dones give 4, 9, 16.
- Same window under profile 0, 1, 3 and eqVal=8'hFF -> result_o = 4, 10, 1, 4 respectively.
- Negative input, eqVal=0, signal=24'hFFFF00 (-1) -> result_o = 34'h3_FFFF_FFFF (-1).
- signal_en held high continuously -> only every 6th-cycle sample is accepted.
  - done pulses exactly once per accepted sample, 5 edges after acceptance.
- Assert reset during MAC (2 cycles after acceptance) -> result_o=0, done stays 0, window cleared.
  - The next accepted sample computes from a zeroed window.
